// File: rtl/seq_serializer_if.sv
// Handshake and serial-output bundle for seq_serializer.
// master = upstream word source / line observer, slave = the serializer.
interface seq_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, sout, sout_valid, busy, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end feeding the bit-serial sequence detector.
// Define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input logic              clk,
    input logic              rst,
    seq_serializer_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SEQ_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
    logic par_q, par_d;
`else
    typedef enum logic {StIdle, StShift} state_e;
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  shreg_adv;
    logic              head;
    logic              last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Head bit sits at the end selected by MSB_FIRST; advancing shifts toward it.
    always_comb begin
        if (MSB_FIRST != 0) begin
            head      = shreg_q[WIDTH-1];
            shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            head      = shreg_q[0];
            shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
        end
        last = (cnt_q == CntW'(WIDTH - 1));
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
`ifdef SEQ_SERIALIZER_PARITY_EN
        par_d          = par_q;
`endif
        bus.load_ready = 1'b0;
        bus.sout       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shreg_d = bus.load_data;
`ifdef SEQ_SERIALIZER_PARITY_EN
                    par_d   = ^bus.load_data;
`endif
                end
            end
            StShift: begin
                bus.sout       = head;
                bus.sout_valid = 1'b1;
                shreg_d        = shreg_adv;
                cnt_d          = cnt_q + CntW'(1);
                if (last) begin
                    cnt_d = '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
                    state_d = StParity;
`else
                    bus.done       = 1'b1;
                    bus.load_ready = 1'b1;
                    if (bus.load_valid) begin
                        shreg_d = bus.load_data;
                    end else begin
                        state_d = StIdle;
                    end
`endif
                end
            end
`ifdef SEQ_SERIALIZER_PARITY_EN
            StParity: begin
                bus.sout       = par_q;
                bus.sout_valid = 1'b1;
                bus.done       = 1'b1;
                bus.load_ready = 1'b1;
                cnt_d          = '0;
                if (bus.load_valid) begin
                    state_d = StShift;
                    shreg_d = bus.load_data;
                    par_d   = ^bus.load_data;
                end else begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        bus.busy = bus.sout_valid;
    end
endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: directed scenarios plus randomized traffic
// compared against a bit-queue model of the serial line.
module tb_seq_serializer;
    localparam int W = 8;
`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_serializer_if #(.WIDTH(W)) a ();
    seq_serializer_if #(.WIDTH(W)) b ();

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    seq_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    int errors = 0;
    int checks = 0;

    // Model: bits still to appear on the line, head = bit on sout this cycle.
    bit q[$];

    function automatic logic [4:0] exp_vec();
        logic [4:0] ev;
        ev[4] = (q.size() <= 1);
        ev[3] = (q.size() > 0);
        ev[2] = (q.size() > 0) ? q[0] : 1'b0;
        ev[1] = ev[3];
        ev[0] = (q.size() == 1);
        return ev;
    endfunction

    function automatic logic [4:0] obs_vec();
        return {a.load_ready, a.sout_valid, a.sout, a.busy, a.done};
    endfunction

    task automatic step_model(input logic lv, input logic [W-1:0] d, input logic r);
        if (r) begin
            q.delete();
        end else if (lv && q.size() <= 1) begin
            q.delete();
            for (int i = 0; i < W; i++) q.push_back(d[W-1-i]);
`ifdef SEQ_SERIALIZER_PARITY_EN
            q.push_back(^d);
`endif
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end
    endtask

    // Applied at the negedge; the model advances to what the next posedge produces.
    task automatic drive(input logic lv, input logic [W-1:0] d, input logic r);
        a.load_valid = lv;
        a.load_data  = d;
        rst          = r;
        step_model(lv, d, r);
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1'b1, 8'h5A, 1'b1);
        @(negedge clk);
        checks++;
        if (obs_vec() !== 5'b10000) begin
            errors++;
            $display("FAIL reset_a: got %b want %b", obs_vec(), 5'b10000);
        end
        checks++;
        if ({b.load_ready, b.sout_valid, b.sout, b.busy, b.done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_b: got %b want %b",
                     {b.load_ready, b.sout_valid, b.sout, b.busy, b.done}, 5'b10000);
        end
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic test_msb(input logic [W-1:0] w);
        logic [W-1:0] got;
        int dones;
        int done_cyc;
        got = '0;
        dones = 0;
        done_cyc = 0;
        @(negedge clk);
        drive(1'b1, w, 1'b0);
        for (int k = 1; k <= FL + 1; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL msb_vec cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (k <= W) got = {got[W-2:0], a.sout};
            if (a.done === 1'b1) begin
                dones++;
                done_cyc = k;
            end
`ifdef SEQ_SERIALIZER_PARITY_EN
            if (k == FL) begin
                checks++;
                if (a.sout !== ^w) begin
                    errors++;
                    $display("FAIL parity_bit %h: got %b want %b", w, a.sout, ^w);
                end
            end
`endif
            drive(1'b0, '0, 1'b0);
        end
        checks++;
        if (got !== w) begin
            errors++;
            $display("FAIL msb_bits: got %h want %h", got, w);
        end
        checks++;
        if (dones != 1 || done_cyc != FL) begin
            errors++;
            $display("FAIL msb_done: got %0d pulses at %0d want 1 at %0d", dones, done_cyc, FL);
        end
    endtask

    task automatic test_lsb(input logic [W-1:0] w);
        @(negedge clk);
        b.load_valid = 1'b1;
        b.load_data  = w;
        for (int k = 1; k <= FL + 1; k++) begin
            logic ebit;
            logic [4:0] eo;
            logic [4:0] ob;
            @(negedge clk);
            b.load_valid = 1'b0;
            ebit = (k <= W) ? w[k-1] : ((k == FL) ? ^w : 1'b0);
            if (k <= FL) eo = {(k == FL), 1'b1, ebit, 1'b1, (k == FL)};
            else         eo = 5'b10000;
            ob = {b.load_ready, b.sout_valid, b.sout, b.busy, b.done};
            checks++;
            if (ob !== eo) begin
                errors++;
                $display("FAIL lsb_vec cyc%0d: got %b want %b", k, ob, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*FL-1:0] stream;
        logic [2*FL-1:0] exp_s;
        int n;
        int readies;
        int rdy_cyc;
        int dones;
        bit accepted2;
`ifdef SEQ_SERIALIZER_PARITY_EN
        exp_s = {8'hF0, 1'b0, 8'h0F, 1'b0};
`else
        exp_s = {8'hF0, 8'h0F};
`endif
        stream = '0;
        n = 0;
        readies = 0;
        rdy_cyc = 0;
        dones = 0;
        accepted2 = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'hF0, 1'b0);
        for (int k = 1; k <= 2 * FL + 1; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_vec cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (a.sout_valid === 1'b1) begin
                stream = {stream[2*FL-2:0], a.sout};
                n++;
            end
            if (a.load_ready === 1'b1 && k < 2 * FL) begin
                readies++;
                rdy_cyc = k;
            end
            if (a.done === 1'b1) dones++;
            if (!accepted2) begin
                if (q.size() <= 1) accepted2 = 1'b1;
                drive(1'b1, 8'h0F, 1'b0);
            end else begin
                drive(1'b0, '0, 1'b0);
            end
        end
        checks++;
        if (n != 2 * FL || stream !== exp_s) begin
            errors++;
            $display("FAIL b2b_stream: got %0d bits %b want %0d bits %b", n, stream, 2 * FL, exp_s);
        end
        checks++;
        if (readies != 1 || rdy_cyc != FL) begin
            errors++;
            $display("FAIL b2b_ready: got %0d at %0d want 1 at %0d", readies, rdy_cyc, FL);
        end
        checks++;
        if (dones != 2) begin
            errors++;
            $display("FAIL b2b_done: got %0d want 2", dones);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] got;
        bit accepted;
        int acc_cyc;
        got = '0;
        accepted = 1'b0;
        acc_cyc = 0;
        @(negedge clk);
        drive(1'b1, W'($urandom), 1'b0);
        for (int k = 1; k <= 2 * FL + 1; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_vec cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (k > FL && k <= FL + W) got = {got[W-2:0], a.sout};
            if (k >= 2 && !accepted) begin
                if (q.size() <= 1) begin
                    accepted = 1'b1;
                    acc_cyc = k;
                end
                drive(1'b1, 8'h33, 1'b0);
            end else begin
                drive(1'b0, '0, 1'b0);
            end
        end
        checks++;
        if (acc_cyc != FL || got !== 8'h33) begin
            errors++;
            $display("FAIL stall_accept: got cyc %0d word %h want cyc %0d word 33",
                     acc_cyc, got, FL);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got;
        got = '0;
        @(negedge clk);
        drive(1'b1, 8'hFF, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rmid_vec cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (k < 4) drive(1'b0, '0, 1'b0);
            else       drive(1'b1, 8'h81, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (obs_vec() !== 5'b10000) begin
            errors++;
            $display("FAIL rmid_idle: got %b want %b", obs_vec(), 5'b10000);
        end
        drive(1'b1, 8'h81, 1'b0);
        for (int k = 1; k <= FL + 1; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rmid_after cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (k <= W) got = {got[W-2:0], a.sout};
            drive(1'b0, '0, 1'b0);
        end
        checks++;
        if (got !== 8'h81) begin
            errors++;
            $display("FAIL rmid_word: got %h want 81", got);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400 + FL + 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_vec cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (k < 400) drive(($urandom_range(0, 3) != 0), W'($urandom),
                               ($urandom_range(0, 49) == 0));
            else drive(1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        a.load_valid = 1'b0;
        a.load_data  = '0;
        b.load_valid = 1'b0;
        b.load_data  = '0;
        test_reset();
        test_msb(8'hA5);
        test_msb(8'h07);
        test_lsb(8'h0B);
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
